multi_bit_shift_register: RTL and testbench
===========================================

Name: multi_bit_shift_register

Overview:
Fixed-depth, multi-bit delay line. Each rising clock edge shifts a WIDTH-bit word into stage 0 and moves every stage one position toward the output. The last stage drives so, so so is si delayed by exactly POSITIONS clocks. Used as a pipeline-alignment and delay element in datapaths. It has no handshake and shifts on every clock.

Parameters:
POSITIONS  8  number of register stages (delay in clocks); legal range 1..256
WIDTH  8  bits per word; legal range 1..1024

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
si  input  WIDTH  serial word input, sampled every rising clk edge
so  output  WIDTH  output of stage POSITIONS-1 (oldest word)
so_valid  output  1  high when so holds a word actually shifted in since the last reset

Behaviour:
- Storage: POSITIONS registers stage[0..POSITIONS-1], each WIDTH bits.
- Every rising clk edge with rst low:
  - stage[0] <= si
  - stage[i] <= stage[i-1] for i = 1..POSITIONS-1
  - All stages update simultaneously (non-blocking semantics); no enable and no stall.
- so = stage[POSITIONS-1] is driven directly from a flop, with no combinational path from si.
- Latency: a word sampled at edge n appears on so just after edge n+POSITIONS-1 and remains until edge n+POSITIONS. This gives POSITIONS edges from sample to output update.
- POSITIONS = 1: so = si registered once.
- Reset:
  - rst high asynchronously clears every stage to 0, so so = 0 immediately.
  - Reset also clears the fill counter, so so_valid = 0.
  - Reset takes priority over shifting. Reset asserted mid-stream discards all in-flight words.
  - After release, the first rising edge with rst low performs a normal shift.
- so_valid:
  - Saturating fill counter, width clog2(POSITIONS+1), reset to 0.
  - Increments on each non-reset edge until it reaches POSITIONS, then holds.
  - so_valid = (count == POSITIONS), so it asserts on the POSITIONS-th edge after reset release and stays high until the next reset.
- Data is treated as opaque bits; no arithmetic is performed.
- X on si propagates as data and does not affect so_valid.
- Before any reset, stage contents are undefined. Benches must assert rst first.

Optional Feature:
MBSR_TAPS_EN
- Defined: adds output port taps, width POSITIONS*WIDTH, exposing every stage at once. taps[i*WIDTH +: WIDTH] = stage[i]; taps are reset to 0 with the stages.
- Undefined: the taps port does not exist and behaviour is identical otherwise.
- so and so_valid are unaffected either way.

Test Plan:
1. Reset clear: fill stages with nonzero data, then pulse rst between edges. so = 0 and so_valid = 0 immediately, with no clock required.
2. Latency: defaults, rst released, drive si = 1,2,...,14 on successive edges. so shows 0 until edge 8, then 1,2,3,... one per edge. so = 14 after edge 21 (the 8th edge after 14 is sampled).
3. so_valid timing: after reset release, so_valid is 0 for edges 1..7 and goes high on edge 8. It stays high through 100 further edges.
4. Mid-stream reset: during test 2, assert rst after si = 5 is sampled, then release. The following 7 outputs are 0 rather than the discarded words, and so_valid re-asserts only 8 edges after release.
5. Boundaries:
   - POSITIONS = 1, WIDTH = 1: so equals si delayed one edge, and so_valid is high after the first edge.
   - POSITIONS = 8, WIDTH = 32: pattern 0xA5A5A5A5 alternating with 0x5A5A5A5A emerges unaltered after 8 edges.
6. With MBSR_TAPS_EN defined: after shifting 1..8, taps stage[0] = 8 ... stage[7] = 1, and so = 1.

Source files
------------

// File: rtl/multi_bit_shift_register_if.sv
// multi_bit_shift_register_if: data bus of the multi-bit delay line.
// Signals: si (word in), so (oldest word out), so_valid (so holds a real word),
// taps (all stages, only when MBSR_TAPS_EN is defined).
// Modports: master drives si, slave (the delay line) drives the outputs.
interface multi_bit_shift_register_if #(
  parameter int WIDTH = 8
`ifdef MBSR_TAPS_EN
  , parameter int POSITIONS = 8
`endif
);
  logic [WIDTH-1:0] si;
  logic [WIDTH-1:0] so;
  logic so_valid;
`ifdef MBSR_TAPS_EN
  logic [POSITIONS*WIDTH-1:0] taps;
  modport master(output si, input so, so_valid, taps);
  modport slave(input si, output so, so_valid, taps);
`else
  modport master(output si, input so, so_valid);
  modport slave(input si, output so, so_valid);
`endif
endinterface

// File: rtl/multi_bit_shift_register.sv
// multi_bit_shift_register: fixed-depth WIDTH-bit delay line, so = si delayed POSITIONS clocks.
// Ports: clk (rising edge), rst (async, active high), bus (slave modport: si, so, so_valid[, taps]).
// Optional macro MBSR_TAPS_EN exposes every stage on bus.taps (stage i at taps[i*WIDTH +: WIDTH]).
module multi_bit_shift_register #(
  parameter int POSITIONS = 8,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  multi_bit_shift_register_if.slave bus
);
  localparam int CW = $clog2(POSITIONS + 1);
  localparam logic [CW-1:0] FULL = CW'(POSITIONS);
  logic [POSITIONS-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    stage_d[0] = bus.si;
    for (int i = 1; i < POSITIONS; i++) stage_d[i] = stage_q[i-1];
    // fill counter saturates once the pipe holds only post-reset words
    count_d = count_q == FULL ? count_q : count_q + CW'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage_q <= '0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      count_q <= count_d;
    end
  assign bus.so = stage_q[POSITIONS-1];
  assign bus.so_valid = count_q == FULL;
`ifdef MBSR_TAPS_EN
  assign bus.taps = stage_q;
`endif
endmodule

// File: tb/tb_multi_bit_shift_register.sv
// tb_multi_bit_shift_register: directed checks of the default, 1x1 and 8x32 delay lines.
module tb_multi_bit_shift_register;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
`ifdef MBSR_TAPS_EN
  multi_bit_shift_register_if #(.WIDTH(8), .POSITIONS(8)) b0();
  multi_bit_shift_register_if #(.WIDTH(1), .POSITIONS(1)) b1();
  multi_bit_shift_register_if #(.WIDTH(32), .POSITIONS(8)) b2();
`else
  multi_bit_shift_register_if #(.WIDTH(8)) b0();
  multi_bit_shift_register_if #(.WIDTH(1)) b1();
  multi_bit_shift_register_if #(.WIDTH(32)) b2();
`endif
  multi_bit_shift_register #(.POSITIONS(8), .WIDTH(8)) u0(.clk(clk), .rst(rst), .bus(b0.slave));
  multi_bit_shift_register #(.POSITIONS(1), .WIDTH(1)) u1(.clk(clk), .rst(rst), .bus(b1.slave));
  multi_bit_shift_register #(.POSITIONS(8), .WIDTH(32)) u2(.clk(clk), .rst(rst), .bus(b2.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] pat(input int e);
    return e[0] ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
  endfunction
  initial begin
    rst = 1'b1;
    b0.si = '0;
    b1.si = '0;
    b2.si = '0;
    #12;
    chk("rst_so", 64'(b0.so), 64'h0);
    chk("rst_valid", 64'(b0.so_valid), 64'h0);
    chk("rst_so32", 64'(b2.so), 64'h0);
    rst = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      b0.si = e <= 14 ? 8'(e) : 8'h0;
      b1.si = e[0];
      b2.si = pat(e);
      tick();
      chk("lat_so", 64'(b0.so), e >= 8 ? 64'(e - 7) : 64'h0);
      chk("lat_valid", 64'(b0.so_valid), 64'(e >= 8));
      chk("p1_so", 64'(b1.so), 64'(e[0]));
      chk("p1_valid", 64'(b1.so_valid), 64'h1);
      chk("w32_so", 64'(b2.so), e >= 8 ? 64'(pat(e - 7)) : 64'h0);
      chk("w32_valid", 64'(b2.so_valid), 64'(e >= 8));
`ifdef MBSR_TAPS_EN
      if (e == 8)
        for (int i = 0; i < 8; i++) chk("taps", 64'(b0.taps[i*8 +: 8]), 64'(8 - i));
`endif
    end
    for (int e = 0; e < 100; e++) begin
      b0.si = 8'hC3;
      tick();
      chk("valid_hold", 64'(b0.so_valid), 64'h1);
    end
    chk("fill_so", 64'(b0.so), 64'hC3);
    #1 rst = 1'b1;
    #1;
    chk("async_so", 64'(b0.so), 64'h0);
    chk("async_valid", 64'(b0.so_valid), 64'h0);
    chk("async_p1", 64'(b1.so_valid), 64'h0);
    #1 rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      b0.si = 8'(e);
      tick();
      chk("pre_so", 64'(b0.so), 64'h0);
      chk("pre_valid", 64'(b0.so_valid), 64'h0);
    end
    #1 rst = 1'b1;
    #1;
    chk("mid_so", 64'(b0.so), 64'h0);
    #1 rst = 1'b0;
    for (int f = 1; f <= 12; f++) begin
      b0.si = 8'(5 + f);
      tick();
      chk("mid_so", 64'(b0.so), f >= 8 ? 64'(f - 2) : 64'h0);
      chk("mid_valid", 64'(b0.so_valid), 64'(f >= 8));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
